// File: rtl/systolic_mac_array.sv
// Output-stationary systolic MAC array. Skewed data/weight streams feed a ROWS x COLS
// grid of accumulators (C = A^T * B); results drain one row per valid/ready handshake.
module systolic_mac_array #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int K_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    acc_mode,
   input  logic [K_W-1:0]          k_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ROWS*DATA_W-1:0]  data,
   input  logic [COLS*DATA_W-1:0]  weight,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(ROWS)-1:0] out_row,
   output logic [COLS*ACC_W-1:0]   result,
   output logic                    busy,
   output logic                    done
);
   localparam int RW = $clog2(ROWS);
   localparam int PW = 2 * DATA_W;
   localparam logic [K_W-1:0] DRAIN_LAST = K_W'(ROWS + COLS - 2);

   typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

   state_t                state_q, state_d;
   logic [K_W-1:0]        cnt_q, cnt_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [RW-1:0]         out_row_q, out_row_d, row_sel;
   logic [COLS*ACC_W-1:0] result_q, result_d;
   logic                  fire, clear_acc, acc_en, load_row;

   logic        [DATA_W-1:0] a_in   [ROWS];
   logic        [DATA_W-1:0] a_edge [ROWS];
   logic        [DATA_W-1:0] w_in   [COLS];
   logic        [DATA_W-1:0] w_edge [COLS];
   logic signed [DATA_W-1:0] a_q [ROWS][COLS];
   logic signed [DATA_W-1:0] a_d [ROWS][COLS];
   logic signed [DATA_W-1:0] w_q [ROWS][COLS];
   logic signed [DATA_W-1:0] w_d [ROWS][COLS];
   logic        [ACC_W-1:0]  acc_q [ROWS][COLS];
   logic        [ACC_W-1:0]  acc_d [ROWS][COLS];

   assign fire = in_valid && in_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      row_sel     = out_row_q;
      load_row    = 1'b0;
      clear_acc   = 1'b0;
      acc_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               clear_acc = !acc_mode;
               cnt_d     = k_len;
               if (k_len == '0) begin
                  state_d = OUT;
               end else begin
                  state_d    = FEED;
                  in_ready_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         FEED: begin
            acc_en = 1'b1;
            if (fire) begin
               if (cnt_q == K_W'(1)) begin
                  state_d    = DRAIN;
                  in_ready_d = 1'b0;
                  cnt_d      = DRAIN_LAST;
               end else begin
                  cnt_d = cnt_q - K_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         DRAIN: begin
            acc_en = 1'b1;
            if (cnt_q == '0) begin
               state_d = OUT;
            end else begin
               cnt_d = cnt_q - K_W'(1);
            end
         end
         OUT: begin
            // done_q marks the cycle after the last row left; that cycle still reads busy
            if (done_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (!out_valid_q) begin
               load_row    = 1'b1;
               row_sel     = '0;
               out_row_d   = '0;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               if (out_row_q == RW'(ROWS - 1)) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  load_row  = 1'b1;
                  row_sel   = out_row_q + RW'(1);
                  out_row_d = out_row_q + RW'(1);
               end
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      result_d = result_q;
      for (int j = 0; j < COLS; j++) begin
         if (load_row) begin
            result_d[j*ACC_W +: ACC_W] = acc_q[row_sel][j];
         end else begin
            result_d[j*ACC_W +: ACC_W] = result_q[j*ACC_W +: ACC_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         result_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         result_q    <= result_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Row i is delayed by i cycles and column j by j cycles so operands meet at PE(i,j).
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      assign a_in[i] = fire ? data[i*DATA_W +: DATA_W] : '0;
      if (i == 0) begin : g_none
         assign a_edge[i] = a_in[i];
      end else begin : g_chain
         logic [DATA_W-1:0] sk_q [i];
         logic [DATA_W-1:0] sk_d [i];
         assign sk_d[0] = a_in[i];
         for (genvar k = 1; k < i; k++) begin : g_sh
            assign sk_d[k] = sk_q[k-1];
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sk_q <= '{default: '0};
            else       sk_q <= sk_d;
         end
         assign a_edge[i] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_w_skew
      assign w_in[j] = fire ? weight[j*DATA_W +: DATA_W] : '0;
      if (j == 0) begin : g_none
         assign w_edge[j] = w_in[j];
      end else begin : g_chain
         logic [DATA_W-1:0] sk_q [j];
         logic [DATA_W-1:0] sk_d [j];
         assign sk_d[0] = w_in[j];
         for (genvar k = 1; k < j; k++) begin : g_sh
            assign sk_d[k] = sk_q[k-1];
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sk_q <= '{default: '0};
            else       sk_q <= sk_d;
         end
         assign w_edge[j] = sk_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
      for (genvar j = 0; j < COLS; j++) begin : g_pe_col
         logic signed [PW-1:0] prod;
         if (j == 0) begin : g_a_first
            assign a_d[i][j] = a_edge[i];
         end else begin : g_a_pass
            assign a_d[i][j] = a_q[i][j-1];
         end
         if (i == 0) begin : g_w_first
            assign w_d[i][j] = w_edge[j];
         end else begin : g_w_pass
            assign w_d[i][j] = w_q[i-1][j];
         end
         assign prod = a_q[i][j] * w_q[i][j];
         assign acc_d[i][j] = clear_acc ? '0
                            : (acc_en ? acc_q[i][j] + ACC_W'(prod) : acc_q[i][j]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q   <= '{default: '{default: '0}};
         w_q   <= '{default: '{default: '0}};
         acc_q <= '{default: '{default: '0}};
      end else begin
         a_q   <= a_d;
         w_q   <= w_d;
         acc_q <= acc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign result    = result_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_systolic_mac_array.sv
// Self-checking bench: directed and random tiles against an arithmetic matrix model.
module tb_systolic_mac_array;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 16;
   localparam int AW   = 32;
   localparam int KW   = 16;

   logic                 clk = 1'b0;
   logic                 reset, start, acc_mode, in_valid, out_ready;
   logic                 in_ready, out_valid, busy, done;
   logic [KW-1:0]        k_len;
   logic [ROWS*DW-1:0]   data;
   logic [COLS*DW-1:0]   weight;
   logic [1:0]           out_row;
   logic [COLS*AW-1:0]   result;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0]      ref_acc [ROWS][COLS];
   logic [ROWS*DW-1:0] bd [16];
   logic [COLS*DW-1:0] bw [16];

   systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
      .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .data(data), .weight(weight),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .result(result),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            ref_acc[i][j] = '0;
   endtask

   // C[i][j] += A[k][i] * B[k][j], wrapped to the accumulator width
   task automatic model_beat(input logic [ROWS*DW-1:0] d, input logic [COLS*DW-1:0] w);
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            a = d[i*DW +: DW];
            b = w[j*DW +: DW];
            ref_acc[i][j] = ref_acc[i][j] + AW'(longint'(a) * longint'(b));
         end
      end
   endtask

   function automatic logic [COLS*AW-1:0] exp_row(input int r);
      logic [COLS*AW-1:0] v;
      for (int j = 0; j < COLS; j++) v[j*AW +: AW] = ref_acc[r][j];
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  128'(in_ready),  128'(0));
      check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      check({tag, "_out_row"},   128'(out_row),   128'(0));
      check({tag, "_result"},    128'(result),    128'(0));
      check({tag, "_busy"},      128'(busy),      128'(0));
      check({tag, "_done"},      128'(done),      128'(0));
   endtask

   task automatic run_tile(input logic am, input int k, input int gap_pct, input int stall,
                           input bit poke);
      int n;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      check("idle_before_start", 128'(busy), 128'(0));
      start    = 1'b1;
      acc_mode = am;
      k_len    = KW'(k);
      tick();
      start    = 1'b0;
      acc_mode = 1'($urandom_range(0, 1));
      k_len    = KW'($urandom_range(0, 15));
      if (!am) model_clear();
      check("busy_after_start", 128'(busy), 128'(1));
      check("in_ready_after_start", 128'(in_ready), 128'(k != 0));
      if (poke) begin
         start    = 1'b1;
         acc_mode = 1'b0;
         k_len    = KW'(7);
      end
      for (int b = 0; b < k; b++) begin
         while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            data     = {$urandom, $urandom};
            weight   = {$urandom, $urandom};
            tick();
         end
         in_valid = 1'b1;
         data     = bd[b];
         weight   = bw[b];
         check("in_ready_feed", 128'(in_ready), 128'(1));
         model_beat(bd[b], bw[b]);
         tick();
      end
      in_valid = 1'b0;
      data     = {$urandom, $urandom};
      if (k > 0) check("in_ready_drop", 128'(in_ready), 128'(0));
      n = 0;
      while (!out_valid && n < 64) begin tick(); n++; end
      check("first_row_latency", 128'(n), (k == 0) ? 128'(1) : 128'(ROWS + COLS));
      start = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         if (stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
               check("stall_valid", 128'(out_valid), 128'(1));
               check("stall_row", 128'(out_row), 128'(r));
               check("stall_result", 128'(result), 128'(exp_row(r)));
               tick();
            end
         end
         out_ready = 1'b1;
         check("row_valid", 128'(out_valid), 128'(1));
         check("row_index", 128'(out_row), 128'(r));
         check("row_result", 128'(result), 128'(exp_row(r)));
         tick();
      end
      out_ready = 1'b0;
      check("done_pulse", 128'(done), 128'(1));
      check("busy_at_done", 128'(busy), 128'(1));
      check("valid_after_last", 128'(out_valid), 128'(0));
      tick();
      check("done_clear", 128'(done), 128'(0));
      check("busy_clear", 128'(busy), 128'(0));
   endtask

   task automatic fill_const(input int k, input int dv, input int wv);
      for (int b = 0; b < k; b++) begin
         for (int i = 0; i < ROWS; i++) bd[b][i*DW +: DW] = DW'(dv);
         for (int j = 0; j < COLS; j++) bw[b][j*DW +: DW] = DW'(wv);
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      acc_mode  = 1'b0;
      k_len     = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data      = '0;
      weight    = '0;
      model_clear();
      tick();
      tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // k=1: row i is all (i+1)
      for (int i = 0; i < ROWS; i++) bd[0][i*DW +: DW] = DW'(i + 1);
      for (int j = 0; j < COLS; j++) bw[0][j*DW +: DW] = DW'(1);
      run_tile(1'b0, 1, 0, 0, 1'b0);

      // data = e_k, weight = B row k: result rows equal B
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < ROWS; i++) bd[b][i*DW +: DW] = (i == b) ? DW'(1) : DW'(0);
         for (int j = 0; j < COLS; j++) bw[b][j*DW +: DW] = DW'(10 * b + j);
      end
      run_tile(1'b0, 4, 0, 0, 1'b0);
      run_tile(1'b0, 4, 40, 3, 1'b0);

      fill_const(1, -3, 5);
      run_tile(1'b0, 1, 0, 0, 1'b0);
      run_tile(1'b1, 1, 0, 0, 1'b0);
      run_tile(1'b0, 1, 0, 0, 1'b0);

      fill_const(3, -32768, -32768);
      run_tile(1'b0, 3, 0, 0, 1'b0);

      for (int b = 0; b < 3; b++) begin
         bd[b] = {$urandom, $urandom};
         bw[b] = {$urandom, $urandom};
      end
      run_tile(1'b1, 3, 20, 1, 1'b1);
      run_tile(1'b1, 0, 0, 0, 1'b0);

      // asynchronous reset in the middle of FEED
      start    = 1'b1;
      acc_mode = 1'b0;
      k_len    = KW'(4);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      data     = {$urandom, $urandom};
      weight   = {$urandom, $urandom};
      tick();
      tick();
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("mid_feed_reset");
      model_clear();
      tick();
      #2 reset = 1'b0;
      tick();
      check("busy_after_reset", 128'(busy), 128'(0));
      fill_const(1, 1, 1);
      run_tile(1'b1, 1, 0, 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         int k;
         k = $urandom_range(1, 6);
         for (int b = 0; b < k; b++) begin
            bd[b] = {$urandom, $urandom};
            bw[b] = {$urandom, $urandom};
         end
         run_tile(1'($urandom_range(0, 1)), k, 30, $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
